// File: rtl/display_scan_ctrl.sv
// Time-multiplexed 7-segment scan controller with frame-synchronous value updates.
// Optional build macro: LEADING_ZERO_BLANK_EN (dark leading zero digits).
module display_scan_ctrl #(
    parameter int NDIG     = 4,
    parameter int SCAN_DIV = 50000,
    parameter int DEAD_CYC = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic [4*NDIG-1:0] value,
    input  logic [NDIG-1:0]   dp_mask,
    input  logic [NDIG-1:0]   blank_mask,
    output logic [3:0]        num,
    output logic              dp,
    output logic [NDIG-1:0]   digit_en,
    output logic              pending,
    output logic              frame_done
);
    localparam int MAXC = (SCAN_DIV > DEAD_CYC) ? SCAN_DIV : DEAD_CYC;
    localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;
    localparam int IW   = $clog2(NDIG);

    typedef enum logic {DEAD, SHOW} state_t;

    typedef struct packed {
        logic [4*NDIG-1:0] val;
        logic [NDIG-1:0]   dpm;
        logic [NDIG-1:0]   blk;
    } word_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [IW-1:0]   idx_q, idx_d;
    word_t           stg_q, stg_d, sh_q, sh_d, in_w;
    logic            pend_q, pend_d;
    logic [3:0]      num_q, num_d;
    logic            dp_q, dp_d;
    logic [NDIG-1:0] en_q, en_d;
    logic            fd_q, boundary;
    logic [NDIG-1:0] lz, dark;

    assign in_w = '{val: value, dpm: dp_mask, blk: blank_mask};

`ifdef LEADING_ZERO_BLANK_EN
    // Suppress zero nibbles from the top digit down until a nonzero nibble or a dp.
    always_comb begin
        logic keep;
        lz   = '0;
        keep = 1'b1;
        for (int i = NDIG-1; i >= 1; i--) begin
            if (keep) begin
                if (sh_q.val[4*i +: 4] == 4'd0 && !sh_q.dpm[i]) lz[i] = 1'b1;
                else keep = 1'b0;
            end
        end
    end
`else
    assign lz = '0;
`endif

    assign dark = sh_q.blk | lz;

    // Sequencer: one counter shared by both states, cleared on each transition.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q + 1'b1;
        idx_d    = idx_q;
        boundary = 1'b0;
        case (state_q)
            DEAD: begin
                if (cnt_q == CW'(DEAD_CYC-1)) begin
                    state_d = SHOW;
                    cnt_d   = '0;
                end
            end
            SHOW: begin
                if (cnt_q == CW'(SCAN_DIV-1)) begin
                    state_d = DEAD;
                    cnt_d   = '0;
                    if (idx_q == IW'(NDIG-1)) begin
                        idx_d    = '0;
                        boundary = 1'b1;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = DEAD;
                cnt_d   = '0;
            end
        endcase
    end

    // Shadow only moves at the frame boundary so a visible frame never tears.
    always_comb begin
        stg_d  = stg_q;
        sh_d   = sh_q;
        pend_d = pend_q;
        if (boundary) begin
            if (load) begin
                sh_d   = in_w;
                stg_d  = in_w;
                pend_d = 1'b0;
            end else if (pend_q) begin
                sh_d   = stg_q;
                pend_d = 1'b0;
            end
        end else if (load) begin
            stg_d  = in_w;
            pend_d = 1'b1;
        end
    end

    // Outputs are computed from next state so they line up with the state register.
    always_comb begin
        num_d = num_q;
        dp_d  = dp_q;
        en_d  = '0;
        if (state_d == SHOW) begin
            num_d = sh_q.val[{idx_d, 2'b00} +: 4];
            dp_d  = sh_q.dpm[idx_d];
            if (!dark[idx_d]) en_d = NDIG'(1) << idx_d;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= DEAD;
            cnt_q   <= '0;
            idx_q   <= '0;
            stg_q   <= '0;
            sh_q    <= '0;
            pend_q  <= 1'b0;
            num_q   <= 4'd0;
            dp_q    <= 1'b0;
            en_q    <= '0;
            fd_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            stg_q   <= stg_d;
            sh_q    <= sh_d;
            pend_q  <= pend_d;
            num_q   <= num_d;
            dp_q    <= dp_d;
            en_q    <= en_d;
            fd_q    <= boundary;
        end
    end

    assign num        = num_q;
    assign dp         = dp_q;
    assign digit_en   = en_q;
    assign pending    = pend_q;
    assign frame_done = fd_q;
endmodule

// File: tb/tb_display_scan_ctrl.sv
// Scoreboard bench for display_scan_ctrl: per-cycle expectations from a frame-position model.
module tb_display_scan_ctrl;
    localparam int NDIG = 4;
    localparam int S    = 4;
    localparam int D    = 2;
    localparam int P    = S + D;
    localparam int F    = NDIG * P;

    logic              clk = 1'b0;
    logic              reset;
    logic              load;
    logic [4*NDIG-1:0] value;
    logic [NDIG-1:0]   dp_mask, blank_mask;
    logic [3:0]        num;
    logic              dp, pending, frame_done;
    logic [NDIG-1:0]   digit_en;

    display_scan_ctrl #(.NDIG(NDIG), .SCAN_DIV(S), .DEAD_CYC(D)) dut (
        .clk(clk), .reset(reset), .load(load), .value(value), .dp_mask(dp_mask),
        .blank_mask(blank_mask), .num(num), .dp(dp), .digit_en(digit_en),
        .pending(pending), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0]      num;
        logic            dp;
        logic [NDIG-1:0] en;
        logic            pend;
        logic            fd;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model: position in the frame since reset release plus load bookkeeping.
    int               c;
    logic [15:0]      s_val, h_val;
    logic [3:0]       s_dp, s_bl, h_dp, h_bl;
    logic             m_pend;
    logic [3:0]       e_num;
    logic             e_dp;

    function automatic bit digit_dark(int d);
        bit lzd;
        lzd = 1'b0;
`ifdef LEADING_ZERO_BLANK_EN
        if (d != 0) begin
            lzd = 1'b1;
            for (int j = NDIG-1; j >= d; j--)
                if (((h_val >> (4*j)) & 16'hF) != 0 || h_dp[j]) lzd = 1'b0;
        end
`endif
        return h_bl[d] || lzd;
    endfunction

    task automatic model_reset();
        c = 0; s_val = '0; s_dp = '0; s_bl = '0;
        h_val = '0; h_dp = '0; h_bl = '0; m_pend = 1'b0; e_num = 4'd0; e_dp = 1'b0;
    endtask

    // Drive one cycle of inputs at the negedge, predict the state after the next posedge.
    task automatic cyc(input bit ld, input logic [15:0] v, input logic [3:0] dpm, input logic [3:0] bm);
        exp_t e;
        int d, r;
        load = ld; value = v; dp_mask = dpm; blank_mask = bm;
        c = c + 1;
        if (c % F == 0) begin
            if (ld) begin
                h_val = v; h_dp = dpm; h_bl = bm; s_val = v; s_dp = dpm; s_bl = bm; m_pend = 1'b0;
            end else if (m_pend) begin
                h_val = s_val; h_dp = s_dp; h_bl = s_bl; m_pend = 1'b0;
            end
        end else if (ld) begin
            s_val = v; s_dp = dpm; s_bl = bm; m_pend = 1'b1;
        end
        d = (c / P) % NDIG;
        r = c % P;
        e.en = '0;
        if (r >= D) begin
            e_num = 4'((h_val >> (4*d)) & 16'hF);
            e_dp  = h_dp[d];
            if (!digit_dark(d)) e.en = 4'(1 << d);
        end
        e.num  = e_num;
        e.dp   = e_dp;
        e.pend = m_pend;
        e.fd   = (c % F == 0);
        exp_q.push_back(e);
        @(negedge clk);
    endtask

    task automatic idle(int n);
        for (int i = 0; i < n; i++) cyc(1'b0, $urandom, $urandom, $urandom);
    endtask

    task automatic check_reset_outputs(string tag);
        checks++;
        if (digit_en !== '0 || num !== 4'd0 || dp !== 1'b0 || pending !== 1'b0 || frame_done !== 1'b0) begin
            errors++;
            $display("FAIL %s: got en=%b num=%h dp=%b pend=%b fd=%b, want all zero",
                     tag, digit_en, num, dp, pending, frame_done);
        end
    endtask

    // Monitor: compare every cycle the scoreboard has an expectation for.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                checks++;
                if (digit_en !== e.en || num !== e.num || dp !== e.dp ||
                    pending !== e.pend || frame_done !== e.fd) begin
                    errors++;
                    $display("FAIL scan t=%0t: got en=%b num=%h dp=%b pend=%b fd=%b want en=%b num=%h dp=%b pend=%b fd=%b",
                             $time, digit_en, num, dp, pending, frame_done,
                             e.en, e.num, e.dp, e.pend, e.fd);
                end
            end
        end
    end

    initial begin
        logic [15:0] v;
        logic [3:0]  bm;
        reset = 1'b1; load = 1'b0; value = '0; dp_mask = '0; blank_mask = '0;
        #3;
        check_reset_outputs("reset_state");
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        model_reset();

        idle(2*F);                                  // no load: all zeros, digits cycle
        idle(7);
        cyc(1'b1, 16'h3A71, 4'b0100, 4'b0000);      // mid-frame load, pending until boundary
        idle(2*F);
        idle(5);
        cyc(1'b1, 16'h1111, 4'b0000, 4'b0000);
        idle(3);
        cyc(1'b1, 16'h2222, 4'b0000, 4'b0000);      // last load wins
        idle(2*F);
        while (c % F != F-1) idle(1);
        cyc(1'b1, 16'hBEEF, 4'b0000, 4'b0000);      // load exactly on boundary
        idle(F + 3);
        cyc(1'b1, 16'h1234, 4'b0000, 4'b1010);      // blanked digits 1 and 3
        idle(2*F);
        cyc(1'b1, 16'h0050, 4'b0000, 4'b0000);
        idle(2*F);
        cyc(1'b1, 16'h0000, 4'b0000, 4'b0000);
        idle(2*F);
        cyc(1'b1, 16'h0007, 4'b0100, 4'b0000);
        idle(2*F);

        while (!(((c / P) % NDIG) == 2 && (c % P) >= D)) idle(1);
        reset = 1'b1;                               // async reset mid-SHOW of digit 2
        #1;
        check_reset_outputs("async_reset");
        repeat (3) @(negedge clk);
        check_reset_outputs("reset_hold");
        reset = 1'b0;
        model_reset();
        idle(2*F);

        for (int i = 0; i < 100*F; i++) begin
            if ($urandom_range(19) == 0) begin
                v  = 16'($urandom);
                if ($urandom_range(2) == 0) v = v & 16'h00FF;
                if ($urandom_range(4) == 0) v = 16'h0000;
                bm = ($urandom_range(3) == 0) ? 4'($urandom) : 4'b0000;
                cyc(1'b1, v, 4'($urandom_range(3) == 0 ? $urandom : 0), bm);
            end else begin
                cyc(1'b0, $urandom, $urandom, $urandom);
            end
        end

        repeat (3) @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending expectations, want 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
